fft_ram_ctrl: RTL

FFT_RAM_CTRL -- requirements
Module: fft_ram_ctrl

---
 rtl/fft_ram_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fft_ram_ctrl.sv
// Sample RAM controller for an in-place FFT engine.
// Arbitrates a single-port sample RAM between three owners in turn: the input
// stream (LOAD), the FFT engine (COMPUTE) and the result stream (DRAIN).
module fft_ram_ctrl #(
    parameter int unsigned N_LOG2 = 10,
    parameter bit          BITREV = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    // input sample stream
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    // FFT engine side
    output logic        fft_start,
    input  logic        fft_done,
    input  logic        fft_we,
    input  logic [9:0]  fft_addr,
    input  logic [31:0] fft_wdata,
    output logic [31:0] fft_rdata,
    // result stream
    output logic        o_valid,
    input  logic        o_ready,
    output logic [31:0] o_data,
    // sample RAM
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    // status
    output logic        busy,
    output logic [15:0] frame_cnt
);

    typedef enum logic [1:0] {StLoad, StCompute, StDrain} state_t;

    state_t              state;
    logic [N_LOG2-1:0]   wr_cnt;
    logic [N_LOG2-1:0]   rd_cnt;
    logic [N_LOG2-1:0]   load_addr;

    // Reverses only the low N_LOG2 bits, which is the whole counter width.
    function automatic logic [N_LOG2-1:0] bit_reverse(input logic [N_LOG2-1:0] v);
        logic [N_LOG2-1:0] r;
        for (int i = 0; i < int'(N_LOG2); i++) begin
            r[i] = v[N_LOG2-1-i];
        end
        return r;
    endfunction

    assign load_addr = BITREV ? bit_reverse(wr_cnt) : wr_cnt;

    // FSM, frame counters and registered fft_start/busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StLoad;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            frame_cnt <= '0;
            fft_start <= 1'b0;
            busy      <= 1'b0;
        end else begin
            fft_start <= 1'b0;
            unique case (state)
                StLoad: begin
                    if (s_valid) begin
                        if (&wr_cnt) begin
                            wr_cnt    <= '0;
                            state     <= StCompute;
                            fft_start <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                StCompute: begin
                    // The engine's write in the done cycle is still routed below.
                    if (fft_done) begin
                        state <= StDrain;
                    end
                end
                StDrain: begin
                    if (o_ready) begin
                        if (&rd_cnt) begin
                            rd_cnt    <= '0;
                            frame_cnt <= frame_cnt + 16'd1;
                            state     <= StLoad;
                            busy      <= 1'b0;
                        end else begin
                            rd_cnt <= rd_cnt + 1'b1;
                        end
                    end
                end
                default: state <= StLoad;
            endcase
        end
    end

    // RAM port mux and handshake outputs; every interface is quiet outside its state.
    always_comb begin
        s_ready   = 1'b0;
        o_valid   = 1'b0;
        o_data    = '0;
        fft_rdata = '0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        unique case (state)
            StLoad: begin
                // Gated by rst so nothing is accepted while reset is held.
                s_ready   = ~rst;
                ram_we    = s_valid & ~rst;
                ram_addr  = 16'(load_addr);
                ram_wdata = s_data;
            end
            StCompute: begin
                ram_we    = fft_we;
                ram_addr  = 16'(fft_addr[N_LOG2-1:0]);
                ram_wdata = fft_wdata;
                fft_rdata = ram_rdata;
            end
            StDrain: begin
                o_valid  = 1'b1;
                ram_addr = 16'(rd_cnt);
                o_data   = ram_rdata;
            end
            default: begin
                s_ready = 1'b0;
            end
        endcase
    end

endmodule
